// File: rtl/mmu_controller.sv
// rtl/mmu_controller.sv - CPU load/store/fetch port to word-wide synchronous RAM with byte lanes.
// Optional MMU_MISALIGN_TRAP_EN turns misaligned half/word accesses into faults instead of aligning them.
module mmu_controller #(
  parameter int          MEM_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         mmu_write_enable,
  input  logic                         mmu_read_enable,
  input  logic                         mmu_mem_signed_read,
  input  logic [1:0]                   mmu_mem_data_width,
  input  logic [31:0]                  mmu_address,
  input  logic [31:0]                  mmu_data_in,
  output logic [31:0]                  mmu_data_out,
  output logic                         mmu_mem_ready,
  output logic                         mmu_fault,
  output logic [$clog2(MEM_WORDS)-1:0] ram_addr,
  output logic [31:0]                  ram_wdata,
  output logic [3:0]                   ram_we,
  input  logic [31:0]                  ram_rdata
);

  localparam int          AW    = $clog2(MEM_WORDS);
  localparam logic [32:0] LIMIT = 33'(MEM_WORDS) << 2;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_next;

  logic        req;
  logic [31:0] rel;
  logic [1:0]  off_raw, off_eff;
  logic        misalign, req_fault;
  logic [3:0]  lane_we;
  logic [31:0] lane_wdata;

  logic        is_write, signed_q, fault_q;
  logic [1:0]  width_q, off_q;
  logic [31:0] shifted, load_data;

  assign req     = mmu_write_enable | mmu_read_enable;
  assign rel     = mmu_address - BASE_ADDR;
  assign off_raw = mmu_address[1:0];

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Request decode: alignment policy, fault causes and lane placement.
  always_comb begin
    misalign = 1'b0;
    off_eff  = off_raw;
`ifdef MMU_MISALIGN_TRAP_EN
    misalign = ((mmu_mem_data_width == 2'd1) && off_raw[0]) ||
               ((mmu_mem_data_width == 2'd2) && (off_raw != 2'd0));
`else
    if (mmu_mem_data_width == 2'd1) off_eff = {off_raw[1], 1'b0};
    if (mmu_mem_data_width == 2'd2) off_eff = 2'd0;
`endif
    req_fault = misalign || (mmu_mem_data_width == 2'd3) || ({1'b0, rel} >= LIMIT);

    lane_we    = 4'b0000;
    lane_wdata = mmu_data_in;
    case (mmu_mem_data_width)
      2'd0: begin
        lane_we    = 4'b0001 << off_eff;
        lane_wdata = {4{mmu_data_in[7:0]}};
      end
      2'd1: begin
        lane_we    = 4'b0011 << off_eff;
        lane_wdata = {2{mmu_data_in[15:0]}};
      end
      2'd2:    lane_we = 4'b1111;
      default: lane_we = 4'b0000;
    endcase
  end

  always_comb begin
    shifted   = ram_rdata >> {off_q, 3'b000};
    load_data = shifted;
    case (width_q)
      2'd0: load_data = signed_q ? {{24{shifted[7]}}, shifted[7:0]} : {24'd0, shifted[7:0]};
      2'd1: load_data = signed_q ? {{16{shifted[15]}}, shifted[15:0]} : {16'd0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  // The RAM address and write strobes are registered at the request edge so they
  // are presented during ACCESS; ready/fault are registered at the RESP edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mmu_data_out  <= 32'd0;
      mmu_mem_ready <= 1'b0;
      mmu_fault     <= 1'b0;
      ram_addr      <= '0;
      ram_wdata     <= 32'd0;
      ram_we        <= 4'b0000;
      is_write      <= 1'b0;
      signed_q      <= 1'b0;
      fault_q       <= 1'b0;
      width_q       <= 2'd0;
      off_q         <= 2'd0;
    end else begin
      mmu_mem_ready <= 1'b0;
      mmu_fault     <= 1'b0;
      case (state)
        IDLE: if (req) begin
          is_write  <= mmu_write_enable;
          signed_q  <= mmu_mem_signed_read;
          width_q   <= mmu_mem_data_width;
          off_q     <= off_eff;
          fault_q   <= req_fault;
          ram_addr  <= rel[AW+1:2];
          ram_wdata <= lane_wdata;
          ram_we    <= (mmu_write_enable && !req_fault) ? lane_we : 4'b0000;
        end
        ACCESS: ram_we <= 4'b0000;
        RESP: begin
          mmu_mem_ready <= 1'b1;
          mmu_fault     <= fault_q;
          if (fault_q)       mmu_data_out <= 32'd0;
          else if (!is_write) mmu_data_out <= load_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mmu_controller.sv
// tb/tb_mmu_controller.sv - directed self-checking bench for mmu_controller with a behavioural RAM.
module tb_mmu_controller;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        write_enable = 1'b0, read_enable = 1'b0, signed_read = 1'b0;
  logic [1:0]  data_width = 2'd0;
  logic [31:0] address = 32'd0, data_in = 32'd0;
  logic [31:0] data_out, ram_wdata, ram_rdata;
  logic        mem_ready, fault;
  logic [11:0] ram_addr;
  logic [3:0]  ram_we;

  logic [31:0] mem [0:4095];

  int          n_asserts = 0;
  int          n_fail    = 0;
  int          lat;
  logic [3:0]  we_acc, we_any;
  logic [11:0] addr_acc;
  logic [31:0] wdata_acc, r_data;
  logic        r_fault, ready_seen;

  mmu_controller dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .mmu_write_enable    (write_enable),
    .mmu_read_enable     (read_enable),
    .mmu_mem_signed_read (signed_read),
    .mmu_mem_data_width  (data_width),
    .mmu_address         (address),
    .mmu_data_in         (data_in),
    .mmu_data_out        (data_out),
    .mmu_mem_ready       (mem_ready),
    .mmu_fault           (fault),
    .ram_addr            (ram_addr),
    .ram_wdata           (ram_wdata),
    .ram_we              (ram_we),
    .ram_rdata           (ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ram_rdata <= mem[ram_addr];
    for (int i = 0; i < 4; i++)
      if (ram_we[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_access(input logic wr, input logic rd, input logic sgn,
                           input logic [1:0] w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    write_enable = wr; read_enable = rd; signed_read = sgn;
    data_width = w; address = a; data_in = d;
    @(posedge clk);
    lat = 0; we_any = 4'b0000; r_fault = 1'b0; r_data = 32'd0;
    for (int i = 1; i <= 6 && lat == 0; i++) begin
      @(negedge clk);
      if (i == 1) begin
        we_acc = ram_we; addr_acc = ram_addr; wdata_acc = ram_wdata;
        write_enable = 1'b0; read_enable = 1'b0;
      end
      we_any |= ram_we;
      if (mem_ready) begin
        lat = i; r_fault = fault; r_data = data_out;
      end
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(mem_ready), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_data", data_out, 32'd0);
    check("rst_addr", 32'(ram_addr), 32'd0);
    check("rst_we", 32'(ram_we), 32'd0);
    check("rst_wdata", ram_wdata, 32'd0);
    reset_n = 1'b1;

    do_access(1, 0, 0, 2'd2, 32'h10, 32'hDEADBEEF);
    check("sw_we", 32'(we_acc), 32'hF);
    check("sw_addr", 32'(addr_acc), 32'd4);
    check("sw_lat", lat, 3);
    check("sw_fault", 32'(r_fault), 32'd0);
    do_access(0, 1, 0, 2'd2, 32'h10, 32'd0);
    check("lw_lat", lat, 3);
    check("lw_data", r_data, 32'hDEADBEEF);

    do_access(1, 0, 0, 2'd0, 32'h13, 32'h0000_0080);
    check("sb_we", 32'(we_acc), 32'h8);
    check("sb_wdata", wdata_acc, 32'h80808080);
    do_access(0, 1, 1, 2'd0, 32'h13, 32'd0);
    check("lb_signed", r_data, 32'hFFFFFF80);
    do_access(0, 1, 0, 2'd0, 32'h13, 32'd0);
    check("lb_unsigned", r_data, 32'h00000080);

    do_access(1, 0, 0, 2'd2, 32'h20, 32'h11223344);
    do_access(1, 0, 0, 2'd1, 32'h22, 32'h0000_8001);
    check("sh_we", 32'(we_acc), 32'hC);
    check("sh_wdata", wdata_acc, 32'h80018001);
    do_access(0, 1, 1, 2'd1, 32'h22, 32'd0);
    check("lh_signed", r_data, 32'hFFFF8001);
    do_access(0, 1, 0, 2'd2, 32'h20, 32'd0);
    check("lw_after_sh", r_data, 32'h80013344);
    do_access(0, 1, 0, 2'd1, 32'h20, 32'd0);
    check("lh_unsigned", r_data, 32'h00003344);

    do_access(0, 1, 0, 2'd2, 32'h11, 32'd0);
`ifdef MMU_MISALIGN_TRAP_EN
    check("mis_fault", 32'(r_fault), 32'd1);
    check("mis_data", r_data, 32'd0);
`else
    check("mis_fault", 32'(r_fault), 32'd0);
    check("mis_data", r_data, 32'h80ADBEEF);
`endif
    check("mis_we", 32'(we_any), 32'd0);
    do_access(0, 1, 0, 2'd2, 32'h10, 32'd0);
    check("mis_ram", r_data, 32'h80ADBEEF);

    do_access(1, 0, 0, 2'd2, 32'h4000, 32'h12345678);
    check("oor_fault", 32'(r_fault), 32'd1);
    check("oor_we", 32'(we_any), 32'd0);
    check("oor_data", r_data, 32'd0);
    do_access(1, 0, 0, 2'd2, 32'h3FFC, 32'h0BADCAFE);
    check("top_fault", 32'(r_fault), 32'd0);
    do_access(0, 1, 0, 2'd2, 32'h3FFC, 32'd0);
    check("top_data", r_data, 32'h0BADCAFE);
    do_access(0, 1, 0, 2'd3, 32'h10, 32'd0);
    check("w3_fault", 32'(r_fault), 32'd1);
    check("w3_data", r_data, 32'd0);

    @(negedge clk);
    write_enable = 1'b1; data_width = 2'd2; address = 32'h10; data_in = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    check("rsta_we_before", 32'(ram_we), 32'hF);
    write_enable = 1'b0;
    reset_n = 1'b0;
    #1;
    check("rsta_we", 32'(ram_we), 32'd0);
    check("rsta_ready", 32'(mem_ready), 32'd0);
    check("rsta_data", data_out, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    ready_seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      ready_seen |= mem_ready;
    end
    check("rsta_no_ready", 32'(ready_seen), 32'd0);
    do_access(0, 1, 0, 2'd2, 32'h10, 32'd0);
    check("rsta_old_data", r_data, 32'h80ADBEEF);

    do_access(1, 1, 0, 2'd2, 32'h30, 32'h5A5AA5A5);
    check("prio_we", 32'(we_acc), 32'hF);
    check("prio_hold", r_data, 32'h80ADBEEF);
    do_access(0, 1, 0, 2'd2, 32'h30, 32'd0);
    check("prio_data", r_data, 32'h5A5AA5A5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
